// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and checks them
// against build-time constants, with a per-read watchdog against a hung slave.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_1337,
   parameter logic [31:0] EXPECTED_TS    = 32'h594A_6A47,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int unsigned     CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             auto_pend;
   logic             arm;

   // The auto-start launch is held off one cycle after reset release so RD_ID
   // lands on the second rising edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         auto_pend   <= AUTO_START;
         arm         <= 1'b0;
         avm_address <= 1'b0;
         avm_read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         arm  <= 1'b1;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start || (auto_pend && arm)) begin
                  state       <= RD_ID;
                  auto_pend   <= 1'b0;
                  busy        <= 1'b1;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout     <= 1'b0;
                  wait_cnt    <= '0;
               end
            end
            RD_ID, RD_TS: begin
               if (wait_cnt == TO_VAL) begin
                  // Watchdog fired last cycle with the read already dropped.
                  state       <= FINISH;
                  done        <= 1'b1;
                  avm_read    <= 1'b0;
                  avm_address <= 1'b0;
                  wait_cnt    <= '0;
               end else if (avm_waitrequest) begin
                  if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == TO_LAST) begin
                     avm_read <= 1'b0;
                     timeout  <= 1'b1;
                     ts_ok    <= 1'b0;
                     if (state == RD_ID) id_ok <= 1'b0;
                  end
               end else begin
                  wait_cnt <= '0;
                  if (state == RD_ID) begin
                     id_value    <= avm_readdata;
                     id_ok       <= (avm_readdata == EXPECTED_ID);
                     state       <= RD_TS;
                     avm_address <= 1'b1;
                  end else begin
                     ts_value    <= avm_readdata;
                     ts_ok       <= (avm_readdata == EXPECTED_TS);
                     state       <= FINISH;
                     done        <= 1'b1;
                     avm_read    <= 1'b0;
                     avm_address <= 1'b0;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Randomized bench for sysid_checker: a stalling sysid slave model plus a
// cycle-level expectation derived from the read/watchdog rules.
module tb_sysid_checker;

   localparam int unsigned T      = 8;
   localparam logic [31:0] EXP_ID = 32'h0000_1337;
   localparam logic [31:0] EXP_TS = 32'h594A_6A47;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        avm_address, avm_read;
   logic [31:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   logic [31:0] id_word = EXP_ID;
   logic [31:0] ts_word = EXP_TS;
   int          stall_left [2] = '{0, 0};

   // reference model of the last-sequence results
   logic [31:0] m_id_val = '0, m_ts_val = '0;
   logic        m_id_ok = 1'b0, m_ts_ok = 1'b0, m_to = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   sysid_checker #(
      .EXPECTED_ID   (EXP_ID),
      .EXPECTED_TS   (EXP_TS),
      .TIMEOUT_CYCLES(T),
      .AUTO_START    (1'b1)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_readdata   (avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .busy           (busy),
      .done           (done),
      .id_ok          (id_ok),
      .ts_ok          (ts_ok),
      .timeout        (timeout),
      .id_value       (id_value),
      .ts_value       (ts_value)
   );

   // Zero-latency slave: each requested cycle consumes one stall from that word's budget.
   always @(negedge clock) begin
      avm_readdata = avm_address ? ts_word : id_word;
      if (avm_read && stall_left[avm_address] > 0) begin
         avm_waitrequest = 1'b1;
         stall_left[avm_address] = stall_left[avm_address] - 1;
      end else begin
         avm_waitrequest = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, 64'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 64'd0);
      check({tag, "_val"}, {id_value, ts_value}, 64'd0);
   endtask

   // Called at a negedge; the launch is sampled on the following posedge.
   // extra: 0 none, 1 start during RD_TS, 2 start during FINISH, 3 leave for an immediate chained start.
   task automatic run_seq(input logic [31:0] idw, input logic [31:0] tsw, input int id_st,
                          input int ts_st, input int extra, input bit pulse);
      int   done_c, ts_begin;
      bit   id_to, ts_to;
      logic e_read, e_addr, e_busy, e_done;
      id_word = idw;
      ts_word = tsw;
      stall_left[0] = id_st;
      stall_left[1] = ts_st;
      id_to    = (id_st >= int'(T));
      ts_to    = !id_to && (ts_st >= int'(T));
      ts_begin = id_st + 2;
      if (id_to)      done_c = int'(T) + 2;
      else if (ts_to) done_c = ts_begin + int'(T) + 1;
      else            done_c = ts_begin + ts_st + 1;
      if (!id_to)           begin m_id_val = idw; m_id_ok = (idw == EXP_ID); end
      else                  m_id_ok = 1'b0;
      if (!id_to && !ts_to) begin m_ts_val = tsw; m_ts_ok = (tsw == EXP_TS); end
      else                  m_ts_ok = 1'b0;
      m_to = id_to || ts_to;
      if (pulse) start = 1'b1;
      for (int c = 1; c <= done_c + 1; c++) begin
         @(negedge clock);
         start  = 1'b0;
         e_busy = (c <= done_c);
         e_done = (c == done_c);
         if (id_to) begin
            e_read = (c <= int'(T));
            e_addr = 1'b0;
         end else if (c < ts_begin) begin
            e_read = 1'b1;
            e_addr = 1'b0;
         end else begin
            e_addr = 1'b1;
            e_read = ts_to ? (c < ts_begin + int'(T)) : (c < done_c);
         end
         check("bus", 64'({busy, done, avm_read, avm_read & avm_address}),
               64'({e_busy, e_done, e_read, e_read & e_addr}));
         if (c == 1) check("clear", 64'({id_ok, ts_ok, timeout}), 64'd0);
         if (c == done_c) begin
            check("flags", 64'({id_ok, ts_ok, timeout}), 64'({m_id_ok, m_ts_ok, m_to}));
            check("values", {id_value, ts_value}, {m_id_val, m_ts_val});
         end
         if (extra == 1 && !id_to && c == ts_begin) start = 1'b1;
         if (extra == 2 && c == done_c) start = 1'b1;
      end
      if (extra != 3) begin
         @(negedge clock);
         start = 1'b0;
         check("idle", 64'({busy, avm_read}), 64'd0);
      end
   endtask

   task automatic mid_reset();
      stall_left[0] = 5;
      stall_left[1] = 0;
      id_word = EXP_ID;
      ts_word = EXP_TS;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("pre_rst_read", 64'(avm_read), 64'd1);
      #2 reset_n = 1'b0;
      #1 check_all_zero("async_rst");
      m_id_val = '0; m_ts_val = '0; m_id_ok = 1'b0; m_ts_ok = 1'b0; m_to = 1'b0;
      @(negedge clock);
      stall_left[0] = 0;
      reset_n = 1'b1;
      @(negedge clock);
      check("auto_hold", 64'(busy), 64'd0);
      run_seq(EXP_ID, EXP_TS, 0, 0, 0, 1'b0);
   endtask

   function automatic logic [31:0] pick_word(input logic [31:0] good);
      logic [31:0] w;
      case ($urandom_range(0, 2))
         0:       w = good;
         1:       w = good ^ (32'd1 << $urandom_range(0, 31));
         default: w = $urandom;
      endcase
      return w;
   endfunction

   function automatic int pick_stall();
      if ($urandom_range(0, 3) == 0) return $urandom_range(T, T + 3);
      return $urandom_range(0, 5);
   endfunction

   initial begin
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clock);
      check("auto_hold", 64'(busy), 64'd0);
      run_seq(EXP_ID, EXP_TS, 0, 0, 0, 1'b0);            // auto-start pass
      run_seq(EXP_ID, 32'h594A_6A48, 0, 0, 0, 1'b1);     // timestamp mismatch
      run_seq(EXP_ID, EXP_TS, 4, 4, 0, 1'b1);            // wait states
      run_seq(EXP_ID, EXP_TS, 0, 20, 0, 1'b1);           // timeout on timestamp
      run_seq(EXP_ID, EXP_TS, 20, 0, 0, 1'b1);           // timeout on ID
      run_seq(EXP_ID, EXP_TS, 0, 0, 1, 1'b1);            // start while busy
      run_seq(EXP_ID, EXP_TS, 1, 2, 2, 1'b1);            // start during FINISH
      run_seq(EXP_ID, EXP_TS, 0, 0, 3, 1'b1);            // restart as busy falls
      run_seq(32'h0000_1336, EXP_TS, 0, 0, 0, 1'b1);
      mid_reset();
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 9) == 0) mid_reset();
         else run_seq(pick_word(EXP_ID), pick_word(EXP_TS), pick_stall(), pick_stall(),
                      (i == 29) ? 0 : int'($urandom_range(0, 3)), 1'b1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
